// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU sram-like bus arbiter.
package cpu_bus_pkg;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/owner_fifo.sv
// In-order FIFO of transaction owners, one entry per outstanding bus transaction.
module owner_fifo
  import cpu_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  owner_t push_owner,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output owner_t head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  owner_t             mem_q [DEPTH];
  owner_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Next-state: write at tail, advance pointers, track occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_owner;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= OWN_INST;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sram_like_bus_arbiter.sv
// Shares one sram-like bus between the CPU inst and data channels, returning
// responses to the issuing master in acceptance order.
module sram_like_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned MAX_OUT      = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        err_data_ok
);

  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  logic             lock_q, lock_d;
  owner_t           lock_own_q, lock_own_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic             err_q, err_d;
  logic             gnt_vld, hs, pop;
  owner_t           gnt_own, head;
  logic             fifo_full, fifo_empty;

  // Grant selection: a locked grant persists, otherwise data first unless inst is starved
  always_comb begin
    gnt_vld = 1'b0;
    gnt_own = OWN_INST;
    if (!rst) begin
      if (lock_q) begin
        gnt_own = lock_own_q;
        gnt_vld = (lock_own_q == OWN_DATA) ? data_req : inst_req;
      end else if (!fifo_full) begin
        if (inst_req && (starve_q == STV_W'(STARVE_LIMIT))) begin
          gnt_vld = 1'b1;
          gnt_own = OWN_INST;
        end else if (data_req) begin
          gnt_vld = 1'b1;
          gnt_own = OWN_DATA;
        end else if (inst_req) begin
          gnt_vld = 1'b1;
          gnt_own = OWN_INST;
        end
      end
    end
  end

  // Request mux from the granted master, zero when idle
  always_comb begin
    bus_req   = gnt_vld;
    bus_wr    = 1'b0;
    bus_size  = 2'd0;
    bus_addr  = 32'd0;
    bus_wdata = 32'd0;
    if (gnt_vld) begin
      if (gnt_own == OWN_DATA) begin
        bus_wr    = data_wr;
        bus_size  = data_size;
        bus_addr  = data_addr;
        bus_wdata = data_wdata;
      end else begin
        bus_wr    = inst_wr;
        bus_size  = inst_size;
        bus_addr  = inst_addr;
        bus_wdata = inst_wdata;
      end
    end
  end

  assign hs           = gnt_vld & bus_addr_ok;
  assign inst_addr_ok = hs & (gnt_own == OWN_INST);
  assign data_addr_ok = hs & (gnt_own == OWN_DATA);
  assign pop          = bus_data_ok & ~fifo_empty;
  assign err_data_ok  = err_q;

  // Response demux to the owner of the oldest outstanding transaction
  always_comb begin
    inst_data_ok = 1'b0;
    inst_rdata   = 32'd0;
    data_data_ok = 1'b0;
    data_rdata   = 32'd0;
    if (pop) begin
      if (head == OWN_DATA) begin
        data_data_ok = 1'b1;
        data_rdata   = bus_rdata;
      end else begin
        inst_data_ok = 1'b1;
        inst_rdata   = bus_rdata;
      end
    end
  end

  // Next-state for lock, starvation counter and spurious-response flag
  always_comb begin
    lock_d     = gnt_vld & ~bus_addr_ok;
    lock_own_d = gnt_own;
    starve_d   = starve_q;
    err_d      = err_q | (bus_data_ok & fifo_empty);
    if (!inst_req || inst_addr_ok) begin
      starve_d = '0;
    end else if (!(gnt_vld && gnt_own == OWN_INST) &&
                 (starve_q != STV_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_own_q <= OWN_INST;
      starve_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_own_q <= lock_own_d;
      starve_q   <= starve_d;
      err_q      <= err_d;
    end
  end

  owner_fifo #(
    .DEPTH(MAX_OUT)
  ) u_owner_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (hs),
    .push_owner (gnt_own),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (head)
  );

endmodule

// File: tb/tb_sram_like_bus_arbiter.sv
// Randomized bench for sram_like_bus_arbiter against a queue-based reference model.
module tb_sram_like_bus_arbiter;
  import cpu_bus_pkg::*;

  localparam int unsigned MAX_OUT      = 2;
  localparam int unsigned STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_addr_ok, bus_data_ok, err_data_ok;

  sram_like_bus_arbiter #(
    .MAX_OUT      (MAX_OUT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_size     (bus_size),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata),
    .err_data_ok  (err_data_ok)
  );

  always #5 clk = ~clk;

  // Reference model: who owns each outstanding transaction, in acceptance order
  owner_t      m_q[$];
  bit          m_lock;
  owner_t      m_lock_own;
  int          m_starve;
  bit          m_err;
  bit          i_pend, d_pend;

  int unsigned p_inst, p_data, p_aok, p_dok;
  bit          allow_spur, phase_b;
  int          inst_grants;
  int          n_pass, n_checks;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Compliant masters hold their fields until accepted; slave answers randomly
  task automatic drive_inputs();
    if (!i_pend && ($urandom_range(99) < p_inst)) begin
      i_pend     = 1'b1;
      inst_wr    = 1'($urandom_range(1));
      inst_size  = 2'($urandom_range(2));
      inst_addr  = $urandom;
      inst_wdata = $urandom;
    end
    if (!d_pend && ($urandom_range(99) < p_data)) begin
      d_pend     = 1'b1;
      data_wr    = 1'($urandom_range(1));
      data_size  = 2'($urandom_range(2));
      data_addr  = $urandom;
      data_wdata = $urandom;
    end
    inst_req    = i_pend;
    data_req    = d_pend;
    bus_addr_ok = ($urandom_range(99) < p_aok);
    bus_data_ok = ((m_q.size() > 0) || allow_spur) && ($urandom_range(99) < p_dok);
    bus_rdata   = $urandom;
  endtask

  task automatic cycle();
    bit          gv, hs, pop;
    owner_t      g, head;
    logic [67:0] exp_bus;
    logic [32:0] exp_i, exp_d;
    @(negedge clk);
    drive_inputs();
    #1;
    gv = 1'b0;
    g  = OWN_INST;
    if (m_lock) begin
      g  = m_lock_own;
      gv = (g == OWN_DATA) ? data_req : inst_req;
    end else if (m_q.size() < MAX_OUT) begin
      if (inst_req && m_starve == STARVE_LIMIT) begin gv = 1'b1; g = OWN_INST; end
      else if (data_req)                        begin gv = 1'b1; g = OWN_DATA; end
      else if (inst_req)                        begin gv = 1'b1; g = OWN_INST; end
    end
    exp_bus = '0;
    if (gv) exp_bus = (g == OWN_DATA) ? {1'b1, data_wr, data_size, data_addr, data_wdata}
                                      : {1'b1, inst_wr, inst_size, inst_addr, inst_wdata};
    hs   = gv && bus_addr_ok;
    pop  = bus_data_ok && (m_q.size() > 0);
    head = pop ? m_q[0] : OWN_INST;
    exp_i = (pop && head == OWN_INST) ? {1'b1, bus_rdata} : 33'd0;
    exp_d = (pop && head == OWN_DATA) ? {1'b1, bus_rdata} : 33'd0;
    check("bus_fields", 96'({bus_req, bus_wr, bus_size, bus_addr, bus_wdata}), 96'(exp_bus));
    check("inst_addr_ok", 96'(inst_addr_ok), 96'(hs && g == OWN_INST));
    check("data_addr_ok", 96'(data_addr_ok), 96'(hs && g == OWN_DATA));
    check("inst_resp", 96'({inst_data_ok, inst_rdata}), 96'(exp_i));
    check("data_resp", 96'({data_data_ok, data_rdata}), 96'(exp_d));
    check("err_data_ok", 96'(err_data_ok), 96'(m_err));
    @(posedge clk);
    if (pop) void'(m_q.pop_front());
    if (hs) m_q.push_back(g);
    if (bus_data_ok && !pop) m_err = 1'b1;
    if (!inst_req || (hs && g == OWN_INST)) m_starve = 0;
    else if (!(gv && g == OWN_INST) && m_starve < STARVE_LIMIT) m_starve++;
    m_lock     = gv && !bus_addr_ok;
    m_lock_own = g;
    if (hs && g == OWN_INST) begin
      i_pend = 1'b0;
      if (phase_b) inst_grants++;
    end
    if (hs && g == OWN_DATA) d_pend = 1'b0;
  endtask

  // Asynchronous reset asserted mid-cycle with everything requesting
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst         = 1'b1;
    inst_req    = 1'b1;
    data_req    = 1'b1;
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'hA5A5_5A5A;
    #1;
    check("rst_bus", 96'({bus_req, bus_wr, bus_size, bus_addr, bus_wdata}), 96'(0));
    check("rst_ctl", 96'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err_data_ok}), 96'(0));
    check("rst_rdata", 96'({inst_rdata, data_rdata}), 96'(0));
    m_q.delete();
    m_lock   = 1'b0;
    m_starve = 0;
    m_err    = 1'b0;
    i_pend   = 1'b0;
    d_pend   = 1'b0;
    @(negedge clk);
    rst         = 1'b0;
    inst_req    = 1'b0;
    data_req    = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {inst_req, inst_wr, data_req, data_wr, bus_addr_ok, bus_data_ok} = '0;
    {inst_size, data_size} = '0;
    {inst_addr, inst_wdata, data_addr, data_wdata, bus_rdata} = '0;
    m_lock = 1'b0; m_lock_own = OWN_INST; m_starve = 0; m_err = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0; allow_spur = 1'b0; phase_b = 1'b0;
    inst_grants = 0; n_pass = 0; n_checks = 0;
    do_reset();

    // Mixed traffic: locks, full FIFO, interleaved responses
    p_inst = 50; p_data = 50; p_aok = 60; p_dok = 50;
    repeat (1500) cycle();

    // Data always requesting: inst must still get through via starvation priority
    p_inst = 100; p_data = 100; p_aok = 100; p_dok = 70;
    phase_b = 1'b1;
    repeat (200) cycle();
    phase_b = 1'b0;
    check("starved_inst_granted", 96'(inst_grants > 0), 96'(1));

    // Fill outstanding slots, then reset mid-transaction
    p_inst = 50; p_data = 50; p_aok = 100; p_dok = 0;
    repeat (10) cycle();
    do_reset();

    // Stale response after reset is spurious and must stick
    p_inst = 0; p_data = 0; p_dok = 100; allow_spur = 1'b1;
    cycle();
    allow_spur = 1'b0; p_dok = 0;
    repeat (5) cycle();
    #1;
    check("err_sticky", 96'(err_data_ok), 96'(1));

    do_reset();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
